// File: rtl/uart_tx_scheduler.sv
// Buffers UART store bytes in a FIFO and paces them to the transmitter as
// single-cycle uart_we strobes separated by a fixed idle gap.
module uart_tx_scheduler #(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned ADDR_W    = 4,
    parameter int unsigned TX_CYCLES = 1042,
    parameter int unsigned CNT_W     = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [7:0]        wr_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   level,
    output logic              uart_we,
    output logic [7:0]        uart_data,
    output logic [7:0]        drop_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [ADDR_W:0]  DEPTH_L  = (ADDR_W+1)'(DEPTH);
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(TX_CYCLES - 1);

    logic [7:0]        mem_q [DEPTH];
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   level_q, level_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              uart_we_q, uart_we_d;
    logic [7:0]        uart_data_q, uart_data_d;
    logic [7:0]        drop_cnt_q, drop_cnt_d;
    logic              push, pop;

    assign full      = (level_q == DEPTH_L);
    assign empty     = (level_q == '0) && (state_q == IDLE);
    assign level     = level_q;
    assign uart_we   = uart_we_q;
    assign uart_data = uart_data_q;
    assign drop_cnt  = drop_cnt_q;

    // full is the registered occupancy, so a write on the popping edge of a full FIFO is still rejected
    assign push = wr_en && !full;
    assign pop  = (state_q == IDLE) && (level_q != '0);

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        cnt_d       = cnt_q;
        uart_we_d   = 1'b0;
        uart_data_d = uart_data_q;
        drop_cnt_d  = drop_cnt_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end
        case ({push, pop})
            2'b10:   level_d = level_q + (ADDR_W+1)'(1);
            2'b01:   level_d = level_q - (ADDR_W+1)'(1);
            default: level_d = level_q;
        endcase

        if (wr_en && full && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end

        case (state_q)
            IDLE: begin
                if (pop) begin
                    uart_data_d = mem_q[rd_ptr_q];
                    uart_we_d   = 1'b1;
                    state_d     = SEND;
                end
            end
            SEND: begin
                cnt_d   = GAP_LOAD;
                state_d = GAP;
            end
            GAP: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            cnt_q       <= '0;
            uart_we_q   <= 1'b0;
            uart_data_q <= 8'h00;
            drop_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            cnt_q       <= cnt_d;
            uart_we_q   <= uart_we_d;
            uart_data_q <= uart_data_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: cycle model of occupancy/pacing plus a byte
// scoreboard, with directed scenarios for ordering, full/drop and reset.
module tb_uart_tx_scheduler;

    localparam int unsigned DEPTH  = 4;
    localparam int unsigned ADDR_W = 2;
    localparam int unsigned TX     = 4;
    localparam int unsigned CNT_W  = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              wr_en;
    logic [7:0]        wr_data;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   level;
    logic              uart_we;
    logic [7:0]        uart_data;
    logic [7:0]        drop_cnt;

    uart_tx_scheduler #(
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W),
        .TX_CYCLES(TX),
        .CNT_W    (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .empty    (empty),
        .level    (level),
        .uart_we  (uart_we),
        .uart_data(uart_data),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: occupancy, pacing (busy = cycles until back in IDLE), drop counter
    int         m_level = 0;
    int         m_busy  = 0;
    int         m_drop  = 0;
    logic       m_we    = 1'b0;
    logic [7:0] sb[$];
    logic       m_push, m_pop;

    assign m_push = wr_en && (m_level < int'(DEPTH));
    assign m_pop  = (m_busy == 0) && (m_level > 0);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_level <= 0;
            m_busy  <= 0;
            m_drop  <= 0;
            m_we    <= 1'b0;
            sb.delete();
        end else begin
            m_level <= m_level + (m_push ? 1 : 0) - (m_pop ? 1 : 0);
            m_busy  <= m_pop ? int'(TX) + 1 : ((m_busy > 0) ? m_busy - 1 : 0);
            m_we    <= m_pop;
            if (wr_en && (m_level == int'(DEPTH)) && (m_drop < 255)) m_drop <= m_drop + 1;
            if (m_push) sb.push_back(wr_data);
        end
    end

    // Per-cycle checker on the falling edge
    logic [7:0] last_data;
    logic [7:0] sent[$];
    int         rises[$];
    int         pulses = 0;
    int         cyc    = 0;

    initial begin
        last_data = 8'h00;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) last_data = 8'h00;
            check_eq("level", 32'(level), 32'(m_level));
            check_eq("full", 32'(full), 32'(m_level == int'(DEPTH)));
            check_eq("empty", 32'(empty), 32'((m_level == 0) && (m_busy == 0)));
            check_eq("uart_we", 32'(uart_we), 32'(m_we));
            check_eq("drop_cnt", 32'(drop_cnt), 32'(m_drop));
            if (uart_we === 1'b1) begin
                pulses++;
                rises.push_back(cyc);
                sent.push_back(uart_data);
                check_eq("sb_nonempty", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) last_data = sb.pop_front();
            end
            check_eq("uart_data", 32'(uart_data), 32'(last_data));
        end
    end

    task automatic wait_drain(input int bound, input string tag);
        int n = 0;
        while (empty !== 1'b1 && n < bound) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, 32'(n < bound), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int p0;
        int s0;
        int r0;
        rst = 1'b1;
        wr_en = 1'b0;
        wr_data = 8'h00;
        #12;
        check_eq("rst_level", 32'(level), 32'd0);
        check_eq("rst_full", 32'(full), 32'd0);
        check_eq("rst_empty", 32'(empty), 32'd1);
        check_eq("rst_we", 32'(uart_we), 32'd0);
        check_eq("rst_data", 32'(uart_data), 32'h00);
        check_eq("rst_drop", 32'(drop_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single byte into an empty idle block
        wr_en = 1'b1; wr_data = 8'h41;
        @(negedge clk);
        wr_en = 1'b0;
        check_eq("t1_we_early", 32'(uart_we), 32'd0);
        check_eq("t1_level", 32'(level), 32'd1);
        @(negedge clk);
        check_eq("t1_we", 32'(uart_we), 32'd1);
        check_eq("t1_data", 32'(uart_data), 32'h41);
        n = 0;
        while (empty !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("t1_empty_delay", 32'(n), 32'd5);
        check_eq("t1_drop", 32'(drop_cnt), 32'd0);

        // Burst of three, ordering and pulse spacing
        p0 = pulses; s0 = sent.size(); r0 = rises.size();
        wr_en = 1'b1; wr_data = 8'h48;
        @(negedge clk);
        check_eq("t2_level0", 32'(level), 32'd1);
        wr_data = 8'h69;
        @(negedge clk);
        check_eq("t2_level1", 32'(level), 32'd1);
        wr_data = 8'h21;
        @(negedge clk);
        check_eq("t2_level2", 32'(level), 32'd2);
        wr_en = 1'b0;
        wait_drain(100, "t2_drain_timeout");
        check_eq("t2_pulses", 32'(pulses - p0), 32'd3);
        check_eq("t2_b0", 32'(sent[s0]), 32'h48);
        check_eq("t2_b1", 32'(sent[s0+1]), 32'h69);
        check_eq("t2_b2", 32'(sent[s0+2]), 32'h21);
        check_eq("t2_gap01", 32'(rises[r0+1] - rises[r0]), 32'(TX + 2));
        check_eq("t2_gap12", 32'(rises[r0+2] - rises[r0+1]), 32'(TX + 2));

        // Overfill: 7 writes, 2 dropped, 5 transmitted
        p0 = pulses; s0 = sent.size();
        for (int i = 1; i <= 7; i++) begin
            wr_en = 1'b1; wr_data = 8'(i);
            @(negedge clk);
        end
        wr_en = 1'b0;
        check_eq("t3_drop", 32'(drop_cnt), 32'd2);
        check_eq("t3_full", 32'(full), 32'd1);
        check_eq("t3_level", 32'(level), 32'd4);
        wait_drain(200, "t3_drain_timeout");
        check_eq("t3_pulses", 32'(pulses - p0), 32'd5);
        for (int i = 0; i < 5; i++) begin
            check_eq("t3_byte", 32'(sent[s0+i]), 32'(i + 1));
        end

        // Write on the popping edge while full: rejected, pop still happens
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'h10 + i);
            @(negedge clk);
        end
        wr_data = 8'hEE;
        repeat (3) @(negedge clk);
        wr_en = 1'b0;
        check_eq("t4_we", 32'(uart_we), 32'd1);
        check_eq("t4_data", 32'(uart_data), 32'h11);
        check_eq("t4_level", 32'(level), 32'd3);
        check_eq("t4_full", 32'(full), 32'd0);
        check_eq("t4_drop", 32'(drop_cnt), 32'd5);
        wait_drain(200, "t4_drain_timeout");

        // drop_cnt saturation
        wr_en = 1'b1;
        repeat (400) begin
            wr_data = 8'($urandom);
            @(negedge clk);
        end
        check_eq("t5_sat", 32'(drop_cnt), 32'hFF);
        repeat (20) @(negedge clk);
        check_eq("t5_sat_hold", 32'(drop_cnt), 32'hFF);
        wr_en = 1'b0;
        wait_drain(300, "t5_drain_timeout");

        // Asynchronous reset in the gap after the first of three pulses
        wr_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr_data = 8'(8'hA1 + i);
            @(negedge clk);
        end
        wr_en = 1'b0;
        n = 0;
        while (uart_we !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("t6_pulse_timeout", 32'(n < 20), 32'd1);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check_eq("t6_level", 32'(level), 32'd0);
        check_eq("t6_full", 32'(full), 32'd0);
        check_eq("t6_empty", 32'(empty), 32'd1);
        check_eq("t6_we", 32'(uart_we), 32'd0);
        check_eq("t6_drop", 32'(drop_cnt), 32'd0);
        check_eq("t6_data", 32'(uart_data), 32'h00);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        p0 = pulses; s0 = sent.size();
        wr_en = 1'b1; wr_data = 8'h5A;
        @(negedge clk);
        wr_en = 1'b0;
        @(negedge clk);
        check_eq("t6_post_we", 32'(uart_we), 32'd1);
        wait_drain(100, "t6_drain_timeout");
        repeat (10) @(negedge clk);
        check_eq("t6_pulses", 32'(pulses - p0), 32'd1);
        check_eq("t6_byte", 32'(sent[s0]), 32'h5A);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
